method_call_initiator: RTL and testbench



---
 rtl/method_call_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_method_call_initiator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/method_call_initiator.sv
// method_call_initiator
//   Drives the req/busy/return method-call handshake of a generated callee.
//   One start runs ITERATIONS calls. Each call waits for the callee to go
//   idle, raises req until busy is seen, waits for busy to fall, and then
//   compares the captured return value against the value latched at start.
//   The ARM wait and each call are bounded by TIMEOUT cycles. The req hold
//   is bounded by ACK_WINDOW cycles.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   one-cycle pulse that begins a run (ignored unless idle)
//   expected      in   reference return value, sampled at start
//   method_req    out  request to the callee (registered)
//   method_busy   in   callee busy
//   method_return in   callee return value
//   running       out  run in progress
//   done          out  one-cycle end-of-run pulse
//   pass          out  all calls matched and no timeout (valid from done)
//   timeout       out  sticky ACK/completion timeout flag for the run
//   last_return   out  return value of the most recent completed call
//   call_count    out  completed calls in the current run (saturating)
//   fail_count    out  mismatched returns in the current run (saturating)
module method_call_initiator #(
  parameter int unsigned RET_WIDTH  = 32,
  parameter int unsigned ITERATIONS = 1,
  parameter int unsigned ACK_WINDOW = 16,
  parameter int unsigned TIMEOUT    = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RET_WIDTH-1:0] expected,
  output logic                 method_req,
  input  logic                 method_busy,
  input  logic [RET_WIDTH-1:0] method_return,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [RET_WIDTH-1:0] last_return,
  output logic [15:0]          call_count,
  output logic [15:0]          fail_count
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned AW = (ACK_WINDOW < 2) ? 1 : $clog2(ACK_WINDOW);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_WINDOW - 1);
  localparam logic [15:0]   ITER_N   = 16'(ITERATIONS);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    WAIT_DONE,
    CHECK,
    FINISH
  } state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 to_q, to_d;
  logic [RET_WIDTH-1:0] exp_q, exp_d;
  logic [RET_WIDTH-1:0] last_q, last_d;
  logic [15:0]          calls_q, calls_d;
  logic [15:0]          fails_q, fails_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [AW-1:0]        ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      exp_q   <= '0;
      last_q  <= '0;
      calls_q <= '0;
      fails_q <= '0;
      tmr_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      run_q   <= run_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      exp_q   <= exp_d;
      last_q  <= last_d;
      calls_q <= calls_d;
      fails_q <= fails_d;
      tmr_q   <= tmr_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    run_d   = run_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    to_d    = to_q;
    exp_d   = exp_q;
    last_d  = last_q;
    calls_d = calls_q;
    fails_d = fails_q;
    tmr_d   = tmr_q;
    ack_d   = ack_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          calls_d = '0;
          fails_d = '0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
          run_d   = 1'b1;
          tmr_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        tmr_d = tmr_q + TW'(1);
        if (!method_busy) begin
          // req is set on the same edge REQ is entered; the call timer
          // restarts here so it counts from req assertion.
          req_d   = 1'b1;
          tmr_d   = '0;
          ack_d   = '0;
          state_d = REQ;
        end else if (tmr_q == TMR_LAST) begin
          to_d    = 1'b1;
          state_d = FINISH;
        end
      end
      REQ: begin
        tmr_d = tmr_q + TW'(1);
        ack_d = ack_q + AW'(1);
        // busy takes priority over an ACK window expiring on the same cycle
        if (method_busy) begin
          req_d   = 1'b0;
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_LAST || tmr_q == TMR_LAST) begin
          to_d    = 1'b1;
          req_d   = 1'b0;
          state_d = FINISH;
        end
      end
      WAIT_DONE: begin
        tmr_d = tmr_q + TW'(1);
        if (!method_busy) begin
          last_d  = method_return;
          calls_d = (calls_q == 16'hFFFF) ? calls_q : calls_q + 16'd1;
          state_d = CHECK;
        end else if (tmr_q == TMR_LAST) begin
          to_d    = 1'b1;
          state_d = FINISH;
        end
      end
      CHECK: begin
        if (last_q != exp_q) begin
          fails_d = (fails_q == 16'hFFFF) ? fails_q : fails_q + 16'd1;
        end
        if (calls_q == ITER_N) begin
          state_d = FINISH;
        end else begin
          tmr_d   = '0;
          state_d = ARM;
        end
      end
      FINISH: begin
        run_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        run_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // FINISH lasts one cycle, so this fires only on the entering edge and
    // makes done/pass visible together.
    if (state_d == FINISH) begin
      done_d = 1'b1;
      pass_d = (fails_d == 16'd0) && !to_d;
    end
  end

  assign method_req  = req_q;
  assign running     = run_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = to_q;
  assign last_return = last_q;
  assign call_count  = calls_q;
  assign fail_count  = fails_q;

endmodule

// File: tb/tb_method_call_initiator.sv
// Bench for method_call_initiator: instance 0 runs single calls, instance 1
// runs three calls per start. A behavioural callee answers each req; expected
// run results are queued at start and compared when done pulses.
module tb_method_call_initiator;

  typedef struct {
    logic        pass;
    logic        to;
    int          calls;
    int          fails;
    logic [31:0] last;
    int          rlat;    // start sample -> first req rise, -1 = don't care
    int          dlat;    // last req rise -> done, -1 = don't care
    int          reqlen;  // length of last req pulse, -1 = don't care
    int          nreq;    // req pulses during the run
    int          st_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start   [2];
  logic [31:0] expd    [2];
  logic        req     [2];
  logic        busy    [2];
  logic [31:0] mret    [2];
  logic        running [2];
  logic        done    [2];
  logic        pass    [2];
  logic        tmo     [2];
  logic [31:0] lastr   [2];
  logic [15:0] cc      [2];
  logic [15:0] fc      [2];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // callee model controls: 0 normal, 1 never ack, 2 busy forever
  int          cmode [2];
  int          blen  [2];
  int          rem   [2];
  logic [31:0] retq  [2][$];
  logic        samp  [2];

  exp_t        sbq   [2][$];
  int          ndone [2];
  int          base  [2];
  logic        rprev [2];
  int          rise  [2];
  int          first [2];
  int          rlen  [2];
  int          nreq  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  method_call_initiator #(
    .RET_WIDTH(32), .ITERATIONS(1), .ACK_WINDOW(16), .TIMEOUT(10000)
  ) u_dut1 (
    .clk(clk), .reset(rst), .start(start[0]), .expected(expd[0]),
    .method_req(req[0]), .method_busy(busy[0]), .method_return(mret[0]),
    .running(running[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
    .last_return(lastr[0]), .call_count(cc[0]), .fail_count(fc[0])
  );

  method_call_initiator #(
    .RET_WIDTH(32), .ITERATIONS(3), .ACK_WINDOW(16), .TIMEOUT(10000)
  ) u_dut3 (
    .clk(clk), .reset(rst), .start(start[1]), .expected(expd[1]),
    .method_req(req[1]), .method_busy(busy[1]), .method_return(mret[1]),
    .running(running[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
    .last_return(lastr[1]), .call_count(cc[1]), .fail_count(fc[1])
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Callee: samples req at the edge, raises busy for blen cycles.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) samp[g] = req[g];
    #1;
    for (int g = 0; g < 2; g++) begin
      if (busy[g]) begin
        if (cmode[g] != 2) begin
          rem[g] = rem[g] - 1;
          if (rem[g] <= 0) busy[g] = 1'b0;
        end
      end else if (samp[g] && cmode[g] != 1) begin
        busy[g] = 1'b1;
        rem[g]  = blen[g];
        if (retq[g].size() > 0) mret[g] = retq[g].pop_front();
      end
    end
  end

  // Monitor: req timing plus scoreboard comparison on done.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        rprev[g] = 1'b0;
        nreq[g]  = 0;
      end else begin
        if (req[g] && !rprev[g]) begin
          nreq[g]++;
          rise[g] = cyc;
          if (nreq[g] == 1) first[g] = cyc;
          check("req_only_when_idle", busy[g], 0);
        end
        if (!req[g] && rprev[g]) rlen[g] = cyc - rise[g];
        rprev[g] = req[g];
        if (done[g]) begin
          if (sbq[g].size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = sbq[g].pop_front();
            check("pass", pass[g], e.pass);
            check("timeout", tmo[g], e.to);
            check("call_count", cc[g], e.calls);
            check("fail_count", fc[g], e.fails);
            check("last_return", lastr[g], e.last);
            check("running_at_done", running[g], 1);
            check("req_pulses", nreq[g], e.nreq);
            if (e.rlat >= 0) check("req_latency", first[g] - e.st_cyc, e.rlat);
            if (e.dlat >= 0) check("done_latency", cyc - rise[g], e.dlat);
            if (e.reqlen >= 0) check("req_len", rlen[g], e.reqlen);
          end
          nreq[g] = 0;
          ndone[g]++;
        end
      end
    end
  end

  task automatic check_zero(input int g);
    check("rst_req", req[g], 0);
    check("rst_running", running[g], 0);
    check("rst_done", done[g], 0);
    check("rst_pass", pass[g], 0);
    check("rst_timeout", tmo[g], 0);
    check("rst_last", lastr[g], 0);
    check("rst_calls", cc[g], 0);
    check("rst_fails", fc[g], 0);
  endtask

  task automatic launch(input int g, input logic [31:0] ex, input exp_t e);
    @(posedge clk);
    #1 start[g] = 1'b1;
    expd[g] = ex;
    base[g] = ndone[g];
    @(posedge clk);
    #1 start[g] = 1'b0;
    e.st_cyc = cyc;
    check("running_after_start", running[g], 1);
    sbq[g].push_back(e);
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget && ndone[g] == base[g]; i++) @(posedge clk);
    check("done_seen", ndone[g] - base[g], 1);
    @(negedge clk);
    check("done_one_cycle", done[g], 0);
    check("running_cleared", running[g], 0);
  endtask

  function automatic exp_t mk(input logic p, input logic t, input int c,
                              input int f, input logic [31:0] l, input int rl,
                              input int dl, input int ql, input int nq);
    exp_t e;
    e.pass = p; e.to = t; e.calls = c; e.fails = f; e.last = l;
    e.rlat = rl; e.dlat = dl; e.reqlen = ql; e.nreq = nq; e.st_cyc = 0;
    return e;
  endfunction

  initial begin
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; expd[g] = '0; busy[g] = 1'b0; mret[g] = '0;
      cmode[g] = 0; blen[g] = 1; rem[g] = 0; ndone[g] = 0; base[g] = 0;
      rprev[g] = 1'b0; rise[g] = 0; first[g] = 0; rlen[g] = 0; nreq[g] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero(0);
    check_zero(1);

    // 1: busy 5 cycles, return 1, expected 1, start near cycle 100
    while (cyc < 99) @(posedge clk);
    blen[0] = 5; retq[0].push_back(32'd1);
    launch(0, 32'd1, mk(1'b1, 1'b0, 1, 0, 32'd1, 1, 8, 2, 1));
    wait_done(0, 100);

    // 2: return mismatch
    blen[0] = 3; retq[0].push_back(32'd0);
    launch(0, 32'd1, mk(1'b0, 1'b0, 1, 1, 32'd0, 1, 6, 2, 1));
    wait_done(0, 100);

    // 3: callee never acknowledges; req held exactly ACK_WINDOW cycles
    cmode[0] = 1;
    launch(0, 32'd1, mk(1'b0, 1'b1, 0, 0, 32'd0, 1, 16, 16, 1));
    wait_done(0, 100);

    // 4: callee busy forever; done TIMEOUT cycles after req rise
    cmode[0] = 2; blen[0] = 5;
    launch(0, 32'd1, mk(1'b0, 1'b1, 0, 0, 32'd0, 1, 10000, 2, 1));
    wait_done(0, 12000);
    cmode[0] = 0;

    // 5: three calls returning 7,8,7 against 7; a start mid-run is ignored
    blen[1] = 2;
    retq[1].push_back(32'd7); retq[1].push_back(32'd8); retq[1].push_back(32'd7);
    launch(1, 32'd7, mk(1'b0, 1'b0, 3, 1, 32'd7, 1, 5, 2, 3));
    repeat (4) @(posedge clk);
    #1 start[1] = 1'b1; expd[1] = 32'd8;
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_done(1, 200);

    // 6: reset during WAIT_DONE, then a normal run while callee drains
    blen[0] = 50; retq[0].push_back(32'd9);
    launch(0, 32'd9, mk(1'b1, 1'b0, 1, 0, 32'd9, 1, -1, -1, 1));
    repeat (8) @(posedge clk);
    check("in_wait_done_req", req[0], 0);
    check("in_wait_done_busy", busy[0], 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sbq[0].pop_back());
    base[0] = ndone[0];
    check_zero(0);
    check_zero(1);
    repeat (5) @(posedge clk);
    check("no_done_after_reset", ndone[0] - base[0], 0);
    blen[0] = 4; retq[0].push_back(32'd1);
    launch(0, 32'd1, mk(1'b1, 1'b0, 1, 0, 32'd1, -1, 7, 2, 1));
    wait_done(0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
